// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the shared multiply/divide unit: launches the EX-stage op,
// stalls until the result returns, drains flushed ops and serves repeats from a one-entry cache.
module mdu_issue_ctrl #(
   parameter bit          ENABLE_CACHE   = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid_i,
   input  logic [2:0]       op_func3_i,
   input  logic [31:0]      rs1_i,
   input  logic [31:0]      rs2_i,
   input  logic             flush_i,
   input  logic             hold_i,
   output logic             stall_o,
   output logic [31:0]      result_o,
   output logic             result_valid_o,
   output logic             mdu_valid_o,
   output logic [2:0]       mdu_op_o,
   output logic [31:0]      mdu_rs1_o,
   output logic [31:0]      mdu_rs2_o,
   input  logic             mdu_ready_i,
   input  logic [31:0]      mdu_rd_i,
   output logic             timeout_err_o,
   output logic [CNT_W-1:0] op_count_o
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = '1;

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, DRAIN} state_t;

   state_t           state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             drain_tmo;
   logic             cache_vld;
   logic [2:0]       cache_op;
   logic [31:0]      cache_rs1;
   logic [31:0]      cache_rs2;
   logic [31:0]      cache_data;
   logic             cache_hit;
   logic             tmo_hit;

   assign cache_hit = ENABLE_CACHE && cache_vld && (op_func3_i == cache_op) &&
                      (rs1_i == cache_rs1) && (rs2_i == cache_rs2);
   assign tmo_hit   = (tmo_cnt == TMO_LAST);
   assign stall_o   = op_valid_i && !flush_i && (state != DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         drain_tmo      <= 1'b0;
         cache_vld      <= 1'b0;
         cache_op       <= '0;
         cache_rs1      <= '0;
         cache_rs2      <= '0;
         cache_data     <= '0;
         result_o       <= '0;
         result_valid_o <= 1'b0;
         mdu_valid_o    <= 1'b0;
         mdu_op_o       <= '0;
         mdu_rs1_o      <= '0;
         mdu_rs2_o      <= '0;
         timeout_err_o  <= 1'b0;
         op_count_o     <= '0;
      end else begin
         mdu_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid_i && !flush_i) begin
                  mdu_op_o  <= op_func3_i;
                  mdu_rs1_o <= rs1_i;
                  mdu_rs2_o <= rs2_i;
                  if (cache_hit) begin
                     result_o       <= cache_data;
                     result_valid_o <= 1'b1;
                     state          <= DONE;
                  end else begin
                     mdu_valid_o <= 1'b1;
                     state       <= LAUNCH;
                  end
               end
            end
            LAUNCH, WAIT: begin
               // A ready coinciding with a flush is simply discarded; nothing left to drain.
               if (mdu_ready_i) begin
                  if (flush_i) begin
                     state <= IDLE;
                  end else begin
                     result_o       <= mdu_rd_i;
                     result_valid_o <= 1'b1;
                     cache_vld      <= 1'b1;
                     cache_op       <= mdu_op_o;
                     cache_rs1      <= mdu_rs1_o;
                     cache_rs2      <= mdu_rs2_o;
                     cache_data     <= mdu_rd_i;
                     state          <= DONE;
                  end
               end else if ((state == WAIT) && tmo_hit) begin
                  timeout_err_o <= 1'b1;
                  result_o      <= '0;
                  tmo_cnt       <= '0;
                  drain_tmo     <= 1'b1;
                  state         <= DRAIN;
               end else if (flush_i) begin
                  drain_tmo <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  state <= WAIT;
                  if (state == LAUNCH) begin
                     tmo_cnt <= '0;
                  end else if (tmo_cnt != TMO_MAX) begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
               end
            end
            DONE: begin
               if (flush_i) begin
                  result_valid_o <= 1'b0;
                  state          <= IDLE;
               end else if (!hold_i) begin
                  result_valid_o <= 1'b0;
                  op_count_o     <= op_count_o + CNT_W'(1);
                  state          <= IDLE;
               end
            end
            DRAIN: begin
               // After a timeout the MDU may never answer, so bound the drain by one more window.
               if (mdu_ready_i || (drain_tmo && tmo_hit)) begin
                  drain_tmo <= 1'b0;
                  state     <= IDLE;
               end else if (drain_tmo && (tmo_cnt != TMO_MAX)) begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
